// File: rtl/mult_seq_if.sv
// Operand/result bundle between the control unit and the sequential multiplier.
// The master modport is the control unit; the slave modport is mult_seq.
interface mult_seq_if;
    logic        start;
    logic [1:0]  sign;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] productHI;
    logic [31:0] productLO;
    logic        busy;
    logic        done;

    modport master (
        output start, sign, multiplicand, multiplier,
        input  productHI, productLO, busy, done
    );

    modport slave (
        input  start, sign, multiplicand, multiplier,
        output productHI, productLO, busy, done
    );
endinterface

// File: rtl/mult_seq.sv
// Sequential 32x32 radix-2 shift-add multiplier for the HI/LO path (MULT/MULTU).
// Optional MULT_EARLY_EXIT_EN: leave CALC as soon as the remaining multiplier bits are zero.
module mult_seq (
    input  logic       clk,
    input  logic       rst_n,
    mult_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t      state, state_nxt;

    logic [31:0] mcand,   mcand_nxt;
    logic [31:0] mplier,  mplier_nxt;
    logic [63:0] acc,     acc_nxt;
    logic [5:0]  cnt,     cnt_nxt;
    logic        neg,     neg_nxt;
    logic [31:0] prod_hi, prod_hi_nxt;
    logic [31:0] prod_lo, prod_lo_nxt;
    logic        busy_q,  busy_nxt;
    logic        done_q,  done_nxt;

    logic        is_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mplier_shr;
    logic [5:0]  cnt_inc;
    logic [63:0] acc_result;
    logic        exit_calc;
    logic        unused_sign_rsvd;

    // sign[0] is reserved by the control unit and has no effect here
    assign unused_sign_rsvd = bus.sign[0];
    assign is_signed        = bus.sign[1];

    // 0x80000000 negates to itself, which is the correct unsigned magnitude
    assign mag_a = (is_signed && bus.multiplicand[31]) ? (~bus.multiplicand + 32'd1) : bus.multiplicand;
    assign mag_b = (is_signed && bus.multiplier[31])   ? (~bus.multiplier   + 32'd1) : bus.multiplier;

    assign mplier_shr = mplier >> 1;
    assign cnt_inc    = cnt + 6'd1;
    assign acc_result = neg ? (~acc + 64'd1) : acc;

`ifdef MULT_EARLY_EXIT_EN
    assign exit_calc = (cnt_inc == 6'd32) || (mplier_shr == '0);
`else
    assign exit_calc = (cnt_inc == 6'd32);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        neg_nxt     = neg;
        prod_hi_nxt = prod_hi;
        prod_lo_nxt = prod_lo;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    mcand_nxt  = mag_a;
                    mplier_nxt = mag_b;
                    neg_nxt    = is_signed & (bus.multiplicand[31] ^ bus.multiplier[31]);
                    acc_nxt    = '0;
                    cnt_nxt    = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = CALC;
                end
            end

            CALC: begin
                if (mplier[0]) begin
                    acc_nxt = acc + ({32'd0, mcand} << cnt);
                end
                mplier_nxt = mplier_shr;
                cnt_nxt    = cnt_inc;
                if (exit_calc) begin
                    state_nxt = FIX;
                end
            end

            FIX: begin
                prod_hi_nxt = acc_result[63:32];
                prod_lo_nxt = acc_result[31:0];
                done_nxt    = 1'b1;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            prod_hi <= '0;
            prod_lo <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            acc     <= acc_nxt;
            cnt     <= cnt_nxt;
            neg     <= neg_nxt;
            prod_hi <= prod_hi_nxt;
            prod_lo <= prod_lo_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.productHI = prod_hi;
    assign bus.productLO = prod_lo;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule
